// File: rtl/ucsbece154a_fetch_unit_if.sv
// Decode-side handshake of the fetch unit: the head {pc, instr} pair with valid/ready.
interface ucsbece154a_fetch_unit_if;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pcplus4_o;

  modport master (output valid_o, instr_o, pc_o, pcplus4_o, input ready_i);
  modport slave  (input valid_o, instr_o, pc_o, pcplus4_o, output ready_i);
endinterface

// File: rtl/ucsbece154a_fetch_unit.sv
// Fetch stage: PC drives imem and {pc, instr} pairs queue in a DEPTH-entry buffer toward decode.
// One cycle fetch-to-head latency; a full buffer stalls the PC unless decode pops that cycle.
module ucsbece154a_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  output logic [31:0]                     imem_a_o,
  input  logic [31:0]                     imem_rd_i,
  input  logic                            redirect_i,
  input  logic [31:0]                     redirect_pc_i,
  ucsbece154a_fetch_unit_if.master        dec_if,
  output logic                            misaligned_o
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic          misaligned_q, misaligned_d;
  logic [63:0]   buf_q [DEPTH];

  logic          valid;
  logic          pop;
  logic          push;
  logic [63:0]   head;

  // A pop frees a slot in the same cycle, so a full buffer still accepts a push.
  assign valid = (count_q != '0);
  assign pop   = valid & dec_if.ready_i & ~redirect_i;
  assign push  = ~redirect_i & ((count_q != CNT_FULL) | pop);

  always_comb begin
    pc_d         = pc_q;
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    count_d      = count_q;
    misaligned_d = misaligned_q;
    if (redirect_i) begin
      pc_d    = redirect_pc_i & ~32'h3;
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      if (redirect_pc_i[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
      end
    end else begin
      if (push) begin
        wptr_d = wptr_q + PTR_ONE;
        pc_d   = pc_q + 32'd4;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC;
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Payload needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wptr_q] <= {pc_q, imem_rd_i};
    end
  end

  assign head             = buf_q[rptr_q];
  assign imem_a_o         = pc_q;
  assign misaligned_o     = misaligned_q;
  assign dec_if.valid_o   = valid;
  assign dec_if.pc_o      = valid ? head[63:32] : 32'h0;
  assign dec_if.instr_o   = valid ? head[31:0]  : 32'h0;
  assign dec_if.pcplus4_o = valid ? (head[63:32] + 32'd4) : 32'h0;
endmodule

// File: doc/ucsbece154a_fetch_unit.md
# ucsbece154a_fetch_unit

Instruction-fetch stage sitting directly upstream of the instruction memory. Holds the program counter, drives the word-aligned fetch address to imem, captures the combinationally returned instruction word, and buffers {pc, instruction} pairs in a small FIFO. The decode stage consumes these through a valid/ready handshake. Execute redirects the stream on taken branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- DEPTH, 4: fetch-buffer entries; power of two, ≥2.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- imem_a_o  out  32  fetch address to instruction memory; always equals the current PC.
- imem_rd_i  in  32  instruction word from imem, valid combinationally in the same cycle as imem_a_o.
- redirect_i  in  1  execute-stage redirect request (taken branch or jump).
- redirect_pc_i  in  32  redirect target.
- valid_o  out  1  buffer head holds an instruction.
- ready_i  in  1  decode accepts the head this cycle.
- instr_o  out  32  head instruction word.
- pc_o  out  32  head instruction address.
- pcplus4_o  out  32  pc_o + 4 (mod 2^32).
- misaligned_o  out  1  sticky flag: a redirect target had nonzero bits [1:0].

## Operation
- State: PC register, DEPTH×64-bit storage {pc, instr}, read/write pointers of width $clog2(DEPTH) wrapping mod DEPTH, occupancy count of width $clog2(DEPTH)+1 (0..DEPTH).
- pop = valid_o & ready_i & ~redirect_i.
- push = ~redirect_i & ((count != DEPTH) | pop).
- On push: write {PC, imem_rd_i} at wptr, wptr+1, PC <= PC + 4. PC wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- On pop: rptr+1.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with pop in the same cycle: push still occurs, so sustained throughput is 1 instruction per cycle.
- Full without pop: PC holds, imem_a_o holds, no write.
- Redirect (highest priority): flush the buffer (count, rptr, wptr <= 0), discard any pop, no push. PC <= redirect_pc_i & ~32'h3. misaligned_o <= 1 if redirect_pc_i[1:0] != 0.
- misaligned_o stays set until reset.
- Outputs:
  - valid_o = (count != 0).
  - instr_o, pc_o, pcplus4_o come from the head entry when valid_o = 1, and are forced to 0 when valid_o = 0.
- No separate FSM states beyond EMPTY (count = 0), PARTIAL, and FULL (count = DEPTH), implied by count.

## Timing
- Reset (async assert, any time, including mid-stream): PC = RESET_PC, imem_a_o = RESET_PC, count = 0, valid_o = 0, instr_o = pc_o = pcplus4_o = 0, misaligned_o = 0. All buffered entries are lost.
- First rising edge after reset_n deasserts: push of RESET_PC. valid_o = 1 after that edge.
- Fetch-to-decode latency: 1 cycle (push at edge N, visible at head after N if the buffer was empty).
- Redirect latency:
  - redirect_i sampled at edge N: valid_o = 0 after N, imem_a_o = target after N.
  - Target instruction pushed at N+1; valid_o = 1 after N+1.
- Redirect asserted while count = 0 or count = DEPTH: same behaviour, flush plus PC load.
- valid_o never depends combinationally on ready_i. push depends combinationally on ready_i only through pop.

## Test plan
- Reset release, RESET_PC = 0, ready_i = 1, memfile loaded -> imem_a_o = 0,4,8,... on successive cycles. pc_o lags one cycle with instr_o = RAM[pc>>2]. valid_o is continuous, with no bubbles.
- ready_i = 0 from reset -> after 4 edges count = 4, imem_a_o holds 32'h10, and pc_o stays 0. Then ready_i = 1 -> pc_o = 0,4,8,C,10,14 with no gaps and no duplicates.
- Full buffer, redirect_i = 1, redirect_pc_i = 32'h40 -> next cycle valid_o = 0, imem_a_o = 32'h40. The cycle after: valid_o = 1, pc_o = 32'h40, pcplus4_o = 32'h44.
- Redirect with redirect_pc_i = 32'h22 -> PC = 32'h20, misaligned_o = 1. The flag persists after a later aligned redirect and clears only on reset.
- Simultaneous redirect_i and ready_i with valid_o = 1 -> head is not consumed, buffer is flushed, and the old head never reappears.
- Redirect to 32'hFFFF_FFFC, ready_i = 1 -> pc_o sequence FFFF_FFFC, 0000_0000, with pcplus4_o = 0 for the first. Async reset_n pulse mid-stream -> all outputs take their reset values immediately, without waiting for a clock edge.
